// File: rtl/uart_rx_packet.sv
// rtl/uart_rx_packet.sv - UART receiver packing NUM_BYTES frames into one word; optional parity via UART_RX_PARITY_EN
module uart_rx_packet #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int NUM_BYTES    = 16,
    parameter int TIMEOUT_BITS = 32,
    parameter int PARITY_ODD   = 0
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            RX,
    input  logic                            DATA_RETRIEVED,
    output logic                            DATA_READY,
    output logic [NUM_BYTES*DATA_BITS-1:0]  DATA,
    output logic [$clog2(NUM_BYTES+1)-1:0]  BYTE_COUNT,
    output logic                            FRAME_ERR,
    output logic                            OVERRUN,
    output logic                            PARITY_ERR
);

    localparam int CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIW       = $clog2(DATA_BITS + 1);
    localparam int BCW       = $clog2(NUM_BYTES + 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW        = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

    localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_MID   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
    localparam logic [TW-1:0]  TO_LIMIT  = TW'(TO_CYCLES);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;
    localparam logic [2:0] S_FULL      = 3'd6;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif

    logic [2:0]                     state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [BIW-1:0]                 bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]           shift_q, shift_d;
    logic [NUM_BYTES*DATA_BITS-1:0] data_q, data_d;
    logic [BCW-1:0]                 byte_count_q, byte_count_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic                           data_ready_q, data_ready_d;
    logic                           frame_err_q, frame_err_d;
    logic                           overrun_q, overrun_d;
    logic                           rx_meta_q, rx_meta_d;
    logic                           rx_s_q, rx_s_d;
    logic                           rx_prev_q, rx_prev_d;
    logic                           frame_set, overrun_set;
    logic                           stop_discard;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic parity_bad_q, parity_bad_d;
    logic parity_set;
    assign stop_discard = parity_bad_q;
    assign PARITY_ERR   = parity_err_q;
`else
    assign stop_discard = 1'b0;
    assign PARITY_ERR   = 1'b0;
`endif

    assign DATA_READY = data_ready_q;
    assign DATA       = data_q;
    assign BYTE_COUNT = byte_count_q;
    assign FRAME_ERR  = frame_err_q;
    assign OVERRUN    = overrun_q;

    // Next-state logic: synchroniser, frame FSM, packet assembly, timeout and sticky flags
    always_comb begin
        rx_meta_d    = RX;
        rx_s_d       = rx_meta_q;
        rx_prev_d    = rx_s_q;
        state_d      = state_q;
        cnt_d        = '0;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        byte_count_d = byte_count_q;
        data_ready_d = data_ready_q;
        timer_d      = '0;
        frame_set    = 1'b0;
        overrun_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set   = 1'b0;
        parity_bad_d = parity_bad_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A start edge wins over a timeout landing on the same cycle
                if (!rx_s_q) begin
                    state_d = S_START;
                end else if (TO_CYCLES != 0 && byte_count_q != '0) begin
                    timer_d = timer_q + TW'(1);
                    if (timer_d == TO_LIMIT) begin
                        byte_count_d = '0;
                        timer_d      = '0;
                    end
                end
            end
            S_START: begin
                cnt_d = cnt_q + CW'(1);
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_HALF) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MID) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BIW'(1);
                    cnt_d     = '0;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MID) begin
                    state_d = S_STOP;
                    if (rx_s_q != ((^shift_q) ^ (PARITY_ODD != 0))) begin
                        parity_set   = 1'b1;
                        parity_bad_d = 1'b1;
                        byte_count_d = '0;
                    end
                end
            end
`endif
            S_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MID) begin
`ifdef UART_RX_PARITY_EN
                    parity_bad_d = 1'b0;
`endif
                    if (!rx_s_q) begin
                        frame_set    = 1'b1;
                        byte_count_d = '0;
                        state_d      = S_WAIT_HIGH;
                    end else if (stop_discard) begin
                        state_d = S_IDLE;
                    end else begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (byte_count_q == BCW'(k)) begin
                                data_d[k*DATA_BITS +: DATA_BITS] = shift_q;
                            end
                        end
                        byte_count_d = byte_count_q + BCW'(1);
                        if (byte_count_q == LAST_BYTE) begin
                            state_d      = S_FULL;
                            data_ready_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            S_FULL: begin
                if (rx_prev_q && !rx_s_q) begin
                    overrun_set = 1'b1;
                end
                if (DATA_RETRIEVED) begin
                    state_d      = S_IDLE;
                    byte_count_d = '0;
                    data_ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        frame_err_d = frame_set | (frame_err_q & ~DATA_RETRIEVED);
        overrun_d   = overrun_set | (overrun_q & ~DATA_RETRIEVED);
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_set | (parity_err_q & ~DATA_RETRIEVED);
`endif
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            byte_count_q <= '0;
            timer_q      <= '0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            byte_count_q <= byte_count_d;
            timer_q      <= timer_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_packet.sv
// tb/tb_uart_rx_packet.sv - directed self-checking bench for uart_rx_packet
module tb_uart_rx_packet;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int NB  = 16;
    localparam int TOB = 4;
    localparam int BCW = $clog2(NB + 1);

    logic           CLK = 1'b0;
    logic           RST;
    logic           RX;
    logic           DATA_RETRIEVED;
    logic           DATA_READY;
    logic [NB*DB-1:0] DATA;
    logic [BCW-1:0] BYTE_COUNT;
    logic           FRAME_ERR;
    logic           OVERRUN;
    logic           PARITY_ERR;

    int n_vec = 0;
    int n_err = 0;
    logic [NB*DB-1:0] exp_data;

    uart_rx_packet #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .NUM_BYTES    (NB),
        .TIMEOUT_BITS (TOB),
        .PARITY_ODD   (0)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX             (RX),
        .DATA_RETRIEVED (DATA_RETRIEVED),
        .DATA_READY     (DATA_READY),
        .DATA           (DATA),
        .BYTE_COUNT     (BYTE_COUNT),
        .FRAME_ERR      (FRAME_ERR),
        .OVERRUN        (OVERRUN),
        .PARITY_ERR     (PARITY_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_head(input logic [7:0] b);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            RX = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        RX = ^b;
        tick(CPB);
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        RX = stop;
        tick(CPB);
        RX = 1'b1;
    endtask

    task automatic pulse_retrieved();
        DATA_RETRIEVED = 1'b1;
        tick(1);
        DATA_RETRIEVED = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        RX = 1'b1;
        DATA_RETRIEVED = 1'b0;
        tick(3);
        check("rst_ready", 128'(DATA_READY), 128'd0);
        check("rst_count", 128'(BYTE_COUNT), 128'd0);
        check("rst_data", 128'(DATA), 128'd0);
        check("rst_flags", 128'({FRAME_ERR, OVERRUN, PARITY_ERR}), 128'd0);
        RST = 1'b0;
        tick(5);

        // 8-cycle low pulse ends on the last START cycle: rejected
        RX = 1'b0;
        tick(8);
        RX = 1'b1;
        tick(40);
        check("glitch_count", 128'(BYTE_COUNT), 128'd0);
        check("glitch_flags", 128'({FRAME_ERR, OVERRUN, PARITY_ERR}), 128'd0);
        check("glitch_data", 128'(DATA), 128'd0);

        // 9-cycle low pulse is a valid start; frame reads 0xFF, then times out after 64 idle cycles
        RX = 1'b0;
        tick(9);
        RX = 1'b1;
        tick(150);
        check("min_start_count", 128'(BYTE_COUNT), 128'd1);
        check("min_start_byte", 128'(DATA[7:0]), 128'hFF);
        tick(59);
        check("timeout_before", 128'(BYTE_COUNT), 128'd1);
        tick(1);
        check("timeout_at", 128'(BYTE_COUNT), 128'd0);
        check("timeout_no_flag", 128'(FRAME_ERR), 128'd0);

        // Full packet 0x00..0x0F with exact DATA_READY latency
        for (int i = 0; i < 15; i++) begin
            send_frame(8'(i), 1'b1);
        end
        check("pkt_count15", 128'(BYTE_COUNT), 128'd15);
        send_head(8'h0F);
        RX = 1'b1;
        tick(10);
        check("pkt_ready_at_sample", 128'(DATA_READY), 128'd0);
        tick(1);
        check("pkt_ready_after", 128'(DATA_READY), 128'd1);
        check("pkt_count16", 128'(BYTE_COUNT), 128'd16);
        check("pkt_data", 128'(DATA), 128'h0F0E0D0C0B0A09080706050403020100);
        tick(CPB);

        // Overrun while holding
        send_frame(8'hAA, 1'b1);
        tick(CPB);
        check("ovr_flag", 128'(OVERRUN), 128'd1);
        check("ovr_data_held", 128'(DATA), 128'h0F0E0D0C0B0A09080706050403020100);
        check("ovr_ready", 128'(DATA_READY), 128'd1);
        pulse_retrieved();
        check("ret_ready", 128'(DATA_READY), 128'd0);
        check("ret_ovr", 128'(OVERRUN), 128'd0);
        check("ret_count", 128'(BYTE_COUNT), 128'd0);

        // Framing error on byte 4, then a clean packet
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        check("fe_count3", 128'(BYTE_COUNT), 128'd3);
        send_frame(8'h44, 1'b0);
        tick(2 * CPB);
        check("fe_flag", 128'(FRAME_ERR), 128'd1);
        check("fe_count", 128'(BYTE_COUNT), 128'd0);
        pulse_retrieved();
        check("fe_clear", 128'(FRAME_ERR), 128'd0);
        check("fe_ready", 128'(DATA_READY), 128'd0);
        for (int i = 0; i < NB; i++) begin
            exp_data[i*8 +: 8] = 8'h80 + 8'(i);
            send_frame(8'h80 + 8'(i), 1'b1);
        end
        tick(CPB);
        check("fe_pkt_ready", 128'(DATA_READY), 128'd1);
        check("fe_pkt_data", 128'(DATA), 128'(exp_data));
        pulse_retrieved();
        check("fe_pkt_ret", 128'(DATA_READY), 128'd0);

        // Reset during bit 5 of byte 2
        send_frame(8'h5A, 1'b1);
        check("mid_count1", 128'(BYTE_COUNT), 128'd1);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 5; i++) begin
            RX = ((8'h3C >> i) & 8'h01) != 8'h00;
            tick(CPB);
        end
        RX = 1'b1;
        tick(CPB / 2);
        RST = 1'b1;
        tick(1);
        check("mid_rst_count", 128'(BYTE_COUNT), 128'd0);
        check("mid_rst_data", 128'(DATA), 128'd0);
        check("mid_rst_ready", 128'(DATA_READY), 128'd0);
        check("mid_rst_flags", 128'({FRAME_ERR, OVERRUN, PARITY_ERR}), 128'd0);
        RST = 1'b0;
        RX = 1'b1;
        tick(3 * CPB);
        for (int i = 0; i < NB; i++) begin
            exp_data[i*8 +: 8] = 8'(i * 7 + 3);
            send_frame(8'(i * 7 + 3), 1'b1);
        end
        tick(CPB);
        check("post_rst_ready", 128'(DATA_READY), 128'd1);
        check("post_rst_data", 128'(DATA), 128'(exp_data));
        check("post_rst_count", 128'(BYTE_COUNT), 128'd16);
        pulse_retrieved();

`ifdef UART_RX_PARITY_EN
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            RX = (i == 0);
            tick(CPB);
        end
        RX = 1'b0;
        tick(CPB);
        RX = 1'b1;
        tick(2 * CPB);
        check("parity_err", 128'(PARITY_ERR), 128'd1);
        check("parity_count", 128'(BYTE_COUNT), 128'd0);
`else
        check("parity_tied", 128'(PARITY_ERR), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_packet.md
Name: uart_rx_packet

Overview:
Parametrised UART receiver that assembles NUM_BYTES serial frames into one packet word for the ASIC tester datapath. It is fed from the BeagleBone Black serial line and handed to downstream command logic with a READY/RETRIEVED handshake. It adds the following over the fixed 115200/16-byte receiver:
- configurable bit timing and frame size
- input synchronisation
- stop-bit and framing-error checking
- overrun detection
- inter-byte timeout

Parameters:
CLKS_PER_BIT, 868, CLK cycles per bit (100 MHz / 115200); legal range ≥ 8.
DATA_BITS, 8, data bits per frame (5..9).
NUM_BYTES, 16, frames per packet (1..64).
TIMEOUT_BITS, 32, idle bit-times allowed between frames of a partial packet before it is discarded; 0 disables the timeout.
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd).

Ports:
CLK  in  1  clock.
RST  in  1  reset.
RX  in  1  async serial line, idle high.
DATA_RETRIEVED  in  1  consumer has taken DATA; 1-cycle pulse.
DATA_READY  out  1  packet complete and held.
DATA  out  NUM_BYTES*DATA_BITS  packet; frame k in DATA[k*DATA_BITS +: DATA_BITS], LSB first on the wire.
BYTE_COUNT  out  $clog2(NUM_BYTES+1)  frames accepted in the current packet.
FRAME_ERR  out  1  sticky: a stop bit was sampled low.
OVERRUN  out  1  sticky: a start bit arrived while DATA_READY was high.
PARITY_ERR  out  1  sticky parity error (tied 0 without the macro).

Behaviour:
- Reset: RST is synchronous and active-high; clock is CLK. All state is cleared on the CLK edge where RST=1.
- Reset values: state=IDLE; DATA=0; BYTE_COUNT=0; DATA_READY, FRAME_ERR, OVERRUN and PARITY_ERR = 0; both synchroniser flops = 1.
- RST mid-frame aborts the frame with no partial write.
- Synchroniser: RX passes through 2 flops (rx_s). All decisions use rx_s, so line-to-decision latency is 2 cycles.
- Bit counter: width $clog2(CLKS_PER_BIT). It is cleared on every state change.
- IDLE: on rx_s=0, go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer divide).
  - If rx_s=1 at any cycle before that, it is a glitch: return to IDLE. No outputs change.
  - Otherwise go to DATA with bit index 0.
- DATA: on each counter == CLKS_PER_BIT-1 (mid-bit), shift rx_s into the frame shift register and increment the bit index.
  - After DATA_BITS samples, go to PARITY if the macro is defined, else to STOP.
- STOP: sample at mid-bit.
  - rx_s=1: write the frame into DATA slot BYTE_COUNT and increment BYTE_COUNT. Go to FULL if the new count equals NUM_BYTES, else go to IDLE immediately (mid stop bit, to resync early).
  - rx_s=0: set FRAME_ERR, discard the partial packet (BYTE_COUNT←0; DATA is not cleared), then go to WAIT_HIGH.
- WAIT_HIGH: hold until rx_s=1, then go to IDLE. This prevents a break condition being read as a start bit.
- FULL:
  - DATA_READY=1. DATA and BYTE_COUNT are frozen.
  - RX activity is ignored except that a falling rx_s sets OVERRUN.
  - On DATA_RETRIEVED: go to IDLE, BYTE_COUNT←0, and DATA_READY is low from the next cycle.
- DATA_RETRIEVED outside FULL: no effect except clearing the sticky flags.
- Sticky flags: DATA_RETRIEVED clears FRAME_ERR, OVERRUN and PARITY_ERR. If a flag set and DATA_RETRIEVED occur in the same cycle, set wins.
- DATA_READY latency: it rises on the cycle after the mid-stop sample of frame NUM_BYTES-1.
- Timeout: in IDLE with 0 < BYTE_COUNT < NUM_BYTES, a timer counts idle cycles. It is reset on entry to START.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT, BYTE_COUNT←0. No error flag is raised.
  - A start bit arriving on the same cycle as the timeout takes priority: the timeout is dropped.
- Back-to-back frames: a start edge arriving anywhere after the mid-stop sample must be accepted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state follows DATA and samples one parity bit at mid-bit.
  - Expected parity = XOR of data bits, XOR PARITY_ODD.
  - On mismatch: set PARITY_ERR, discard the packet as for a frame error, then complete the stop bit and go to IDLE.
- Undefined: no parity bit is expected; PARITY_ERR is tied 0 and PARITY_ODD is ignored.

Test Plan:
- Full packet (defaults): send 0x00..0x0F with 1 stop bit each → DATA=128'h0F0E0D0C0B0A09080706050403020100; DATA_READY=1 exactly one cycle after the final mid-stop sample; BYTE_COUNT=16.
- Glitch rejection: RX low for 300 cycles (< 433), then high → state stays IDLE; BYTE_COUNT=0; no flags set.
- Framing error: 3 good bytes, then byte 4 with stop=0, then RX high → FRAME_ERR=1, BYTE_COUNT=0. Then 16 good bytes → DATA_READY=1 with the new data.
- Overrun: after a full packet, send 0xAA without pulsing DATA_RETRIEVED → OVERRUN=1; DATA unchanged. Then DATA_RETRIEVED → DATA_READY=0 and OVERRUN=0 next cycle.
- Timeout (CLKS_PER_BIT=16, TIMEOUT_BITS=4): 5 bytes then idle for 64 cycles → BYTE_COUNT=0 at cycle 64. Then 16 bytes → correct packet.
- Reset mid-frame: assert RST during bit 5 of byte 2 → next cycle all outputs are at reset values. A following full packet is received correctly.
  - With UART_RX_PARITY_EN (even parity): 0x01 with parity 0 → PARITY_ERR=1.
